priority_arbiter_8: RTL
=======================

// Module: priority_arbiter_8
// PURPOSE
//   Grants one of 8 requesters exclusive use of a shared resource; it sequences
//   ownership of that resource.
//   Picks the winner with the same 8:3 priority-encode rule as the datapath encoder:
//   bit 7 highest, index out as 3 bits plus a valid flag.
//   Adds a registered grant, grant hold until release, a hold-limit timeout,
//   and optional round-robin rotation so low-index requesters are not starved.
// PARAMETERS
//   RR_EN     1   1 = rotate priority after each grant, 0 = fixed (bit 7 highest)
//   MAX_HOLD  16  max consecutive grant cycles before forced release; 0 = no limit
// PORTS
//   clk       in   1  rising-edge clock
//   rst       in   1  synchronous, active-high reset
//   req       in   8  request per requester; held high while it wants/uses resource
//   gnt       out  8  one-hot grant, registered
//   gnt_id    out  3  binary index of granted requester (valid when gnt_valid)
//   gnt_valid out  1  1 = a grant is active (OR of gnt)
//   timeout   out  1  one-cycle pulse when a grant is force-released by MAX_HOLD
// BEHAVIOUR
//   Reset (rst=1 at a clock edge)
//   - gnt=0, gnt_id=0, gnt_valid=0, timeout=0, hold_cnt=0, last_id=0, state=IDLE.
//   - Reset mid-grant drops gnt at that edge. No gap cycle is inserted.
//   States: IDLE, GRANT, GAP.
//   IDLE
//   - If req!=0, pick winner W, load gnt=1<<W, gnt_id=W, gnt_valid=1, hold_cnt=0
//     and go to GRANT. Latency is 1 cycle, req sampled at edge n gives gnt high after n.
//   - If req==0, stay in IDLE with outputs 0.
//   Winner selection
//   - RR_EN=0: highest set index of req.
//   - RR_EN=1: search last_id-1, last_id-2, ... wrapping 0->7, ending at last_id.
//     The first set bit wins.
//   - last_id resets to 0, so the first search order is 7..0, same as fixed mode.
//   - last_id<=W on every grant.
//   GRANT
//   - hold_cnt increments each cycle the grant stays active.
//   - Normal release: if req[gnt_id]==0 at an edge, clear gnt/gnt_valid and go to GAP.
//   - Forced release: if MAX_HOLD!=0, req[gnt_id]==1 and hold_cnt==MAX_HOLD-1, clear gnt,
//     pulse timeout=1 for exactly one cycle, and go to GAP. gnt is high MAX_HOLD cycles.
//   - Changes to other req bits during GRANT are ignored; there is no preemption.
//   GAP
//   - One cycle with all grant outputs 0 (bus turnaround), then IDLE unconditionally.
//   - Back-to-back grants are therefore separated by 2 idle cycles (GAP + IDLE decision).
//   Requester rules
//   - A timed-out requester still holding req re-arbitrates normally.
//   - With RR_EN=1 it becomes lowest priority.
//   - With RR_EN=0 it wins again if it is still the highest index.
//   Width / invariants
//   - hold_cnt width is $clog2(MAX_HOLD+1), minimum 1. It never wraps while in GRANT.
//   - gnt is always one-hot or zero. gnt_valid == |gnt.
//   - gnt_id is held at its last value while gnt_valid=0.
//   - timeout is never high in the same cycle as gnt_valid.
// TESTING
//   T1 reset
//   - req=8'hFF with rst=1 for 3 cycles -> gnt=0, gnt_valid=0, timeout=0 throughout.
//   - After rst falls, the first grant is gnt=8'h80, gnt_id=7.
//   T2 fixed priority (RR_EN=0)
//   - req=8'h14 -> gnt=8'h10, id=4 one cycle later.
//   - Drop req[4] -> gnt=0 (GAP), IDLE, then gnt=8'h04, id=2.
//   T3 round-robin (RR_EN=1)
//   - req=8'h81 held, each grant released after 2 cycles by pulsing the owner's req low.
//   - Required grant sequence: 7, 0, 7, 0.
//   - With req=8'hFF, the sequence is 7,6,5,...,0,7.
//   T4 timeout (MAX_HOLD=4)
//   - req=8'h08 held constantly -> gnt=8'h08 for exactly 4 cycles, then timeout=1 for one
//     cycle with gnt=0.
//   - Regrant of id 3 follows after the IDLE cycle.
//   T5 no preemption
//   - While id=2 is granted, raise req[7] -> gnt stays 8'h04 until req[2] drops.
//   - Then id 7 is granted after GAP+IDLE.
//   T6 reset mid-grant and MAX_HOLD=0
//   - Assert rst during GRANT -> gnt=0 at that edge, state IDLE.
//   - With MAX_HOLD=0, a 100-cycle hold never produces a timeout.

Source files
------------

// File: rtl/priority_arbiter_8.sv
// Eight-way arbiter with registered one-hot grant, hold-until-release,
// optional hold-limit timeout and optional round-robin priority rotation.
module priority_arbiter_8 #(
  parameter int unsigned RR_EN    = 1,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] HOLD_SAT  = '1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic [2:0]    last_id, last_d;
  logic [7:0]    gnt_d;
  logic [2:0]    id_d;
  logic          timeout_d;

  logic [2:0]    win_id;
  logic          win_found;
  logic [2:0]    cand;
  logic          hold_expire;

  assign gnt_valid   = |gnt;
  assign hold_expire = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  // Round-robin search starts just below the previous winner and ends on it.
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    cand      = '0;
    if (RR_EN != 0) begin
      for (int unsigned k = 1; k <= 8; k++) begin
        cand = last_id - 3'(k);
        if (!win_found && req[cand]) begin
          win_found = 1'b1;
          win_id    = cand;
        end
      end
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (req[3'(i)]) begin
          win_id = 3'(i);
        end
      end
      win_found = |req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      last_id  <= '0;
    end else begin
      state_q  <= state_d;
      gnt      <= gnt_d;
      gnt_id   <= id_d;
      timeout  <= timeout_d;
      hold_cnt <= hold_d;
      last_id  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = GRANT;
      GRANT:   if (!req[gnt_id] || hold_expire) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; a normal release wins over a timeout.
  always_comb begin
    gnt_d     = '0;
    id_d      = gnt_id;
    timeout_d = 1'b0;
    hold_d    = hold_cnt;
    last_d    = last_id;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d  = 8'b1 << win_id;
          id_d   = win_id;
          hold_d = '0;
          last_d = win_id;
        end
      end
      GRANT: begin
        if (req[gnt_id] && !hold_expire) begin
          gnt_d = gnt;
          if (hold_cnt != HOLD_SAT) hold_d = hold_cnt + 1'b1;
        end else if (req[gnt_id]) begin
          timeout_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
